// File: rtl/mem_port_arbiter_pkg.sv
// ==========================================================================
// Package : mem_arb_pkg
// Arbiter state encoding and memory access-length codes.
// Revision: 1.0
// ==========================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Access-length codes shared with the controller and the data memory
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ==========================================================================
// Interface : mem_port_arbiter_if
// Fetch, load/store and shared-memory signals of the memory port arbiter.
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [11:0]       if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [1:0]        dm_len;
    logic              dm_sign;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic              stall_if;
    logic              stall_mem;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_len;
    logic              mem_sign;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport master (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_len, dm_sign,
               mem_ready, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, mem_len, mem_sign
    );

    // Pipeline and memory side
    modport slave (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_len, dm_sign,
               mem_ready, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, mem_len, mem_sign
    );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ==========================================================================
// Module : mem_port_arbiter
// Shares one single-ported memory between instruction fetch and load/store.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int              CNT_W        = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(MAX_STARVE);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_grant_i;
    logic             w_grant_d;
    logic             w_dm_req;

    assign w_dm_req      = bus.dm_rd | bus.dm_wr;
    assign bus.stall_mem = w_dm_req & ~bus.dm_valid;
    assign bus.stall_if  = (bus.if_req & ~bus.if_valid) | bus.stall_mem;

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                // Data wins a conflict until fetch has waited MAX_STARVE grants
                if (w_dm_req && !(bus.if_req && (r_starve_cnt == C_STARVE_MAX))) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = BUSY_D;
                    if (bus.if_req && (r_starve_cnt != C_STARVE_MAX))
                        w_starve_nxt = r_starve_cnt + 1'b1;
                end else if (bus.if_req) begin
                    w_grant_i    = 1'b1;
                    w_state_nxt  = BUSY_I;
                    w_starve_nxt = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!bus.if_req)
            w_starve_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_starve_cnt  <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_len   <= '0;
            bus.mem_sign  <= 1'b0;
            bus.if_valid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_valid  <= 1'b0;
            bus.dm_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            bus.if_valid <= 1'b0;
            bus.dm_valid <= 1'b0;
            if (w_grant_d) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.dm_wr;
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_wdata <= bus.dm_wdata;
                bus.mem_len   <= bus.dm_len;
                bus.mem_sign  <= bus.dm_sign;
            end else if (w_grant_i) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= ADDR_W'(bus.if_addr);
                bus.mem_wdata <= {DATA_W{1'b0}};
                bus.mem_len   <= LEN_WORD;
                bus.mem_sign  <= 1'b0;
            end else if ((r_state != IDLE) && bus.mem_ready) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
                // A withdrawn requester gets neither a pulse nor new data
                if ((r_state == BUSY_I) && bus.if_req) begin
                    bus.if_valid <= 1'b1;
                    bus.if_rdata <= bus.mem_rdata;
                end
                if ((r_state == BUSY_D) && w_dm_req) begin
                    bus.dm_valid <= 1'b1;
                    if (!bus.mem_we)
                        bus.dm_rdata <= bus.mem_rdata;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
`default_nettype none

module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int MAXS = 3;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(MAXS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          resp_wait   = 0;
    bit          resp_rand   = 1'b0;
    logic [31:0] resp_data   = 32'h0;
    int          resp_cnt    = 0;
    int          resp_cur    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: raises mem_ready after resp_cur wait cycles of mem_req
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_req) begin
                bus.mem_ready = (resp_cnt == resp_cur);
                bus.mem_rdata = resp_rand ? $urandom : resp_data;
                resp_cnt++;
            end else begin
                resp_cnt      = 0;
                resp_cur      = resp_rand ? int'($urandom_range(0, 3)) : resp_wait;
                bus.mem_ready = resp_rand ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_len, bus.mem_sign,
             bus.if_valid, bus.if_rdata, bus.dm_valid, bus.dm_rdata, bus.stall_if, bus.stall_mem} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b addr=%h ifv=%b dmv=%b stall=%b%b, expected all zero",
                     bus.mem_req, bus.mem_addr, bus.if_valid, bus.dm_valid, bus.stall_if, bus.stall_mem);
        end
        resp_wait  = 10;
        bus.dm_rd  = 1'b1;
        bus.dm_addr = 32'h100;
        bus.dm_len = LEN_WORD;
        #1;
        vectors++;
        if ({bus.stall_if, bus.stall_mem} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_stall_comb: got %b, expected 11", {bus.stall_if, bus.stall_mem});
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_d_req: got %b, expected 1", bus.mem_req);
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async_req: got %b, expected 0", bus.mem_req);
        end
        bus.dm_rd   = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h004;
        resp_wait   = 0;
        resp_data   = 32'h0000_0013;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b, expected 0", bus.mem_req);
        end
        tick();
        vectors++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h4}) begin
            miscompares++;
            $display("FAIL reset_release_fetch: got req=%b addr=%h, expected req=1 addr=00000004",
                     bus.mem_req, bus.mem_addr);
        end
        tick();
        vectors++;
        if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h0000_0013}) begin
            miscompares++;
            $display("FAIL reset_release_valid: got v=%b d=%h, expected v=1 d=00000013", bus.if_valid, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch;
        resp_wait   = 0;
        resp_data   = 32'h0050_0093;
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h010;
        #1;
        vectors++;
        if (bus.stall_if !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_stall_n: got %b, expected 1", bus.stall_if);
        end
        tick();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.stall_if, bus.mem_addr} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h10}) begin
            miscompares++;
            $display("FAIL fetch_issue: got req=%b we=%b ifv=%b stall=%b addr=%h, expected 1 0 0 1 00000010",
                     bus.mem_req, bus.mem_we, bus.if_valid, bus.stall_if, bus.mem_addr);
        end
        tick();
        vectors++;
        if ({bus.if_valid, bus.stall_if, bus.mem_req, bus.if_rdata} !== {3'b100, 32'h0050_0093}) begin
            miscompares++;
            $display("FAIL fetch_valid: got ifv=%b stall=%b req=%b d=%h, expected 1 0 0 00500093",
                     bus.if_valid, bus.stall_if, bus.mem_req, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        tick();
        vectors++;
        if (bus.if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_pulse: got %b, expected 0", bus.if_valid);
        end
    endtask

    task automatic test_conflict;
        logic [7:0] got;
        int grants;
        int dmv;
        logic prev;
        got = 8'h00;
        grants = 0;
        dmv = 0;
        resp_wait   = 1;
        resp_data   = 32'h1122_3344;
        bus.if_addr = 12'h123;
        bus.dm_addr = 32'h000A_BC00;
        bus.dm_len  = LEN_WORD;
        bus.dm_rd   = 1'b1;
        bus.if_req  = 1'b1;
        prev = bus.mem_req;
        for (int cyc = 0; cyc < 200 && grants < 8; cyc++) begin
            tick();
            if (bus.dm_valid) dmv++;
            vectors++;
            if (bus.stall_mem !== ~bus.dm_valid) begin
                miscompares++;
                $display("FAIL conflict_stall_mem: got %b, expected %b", bus.stall_mem, ~bus.dm_valid);
            end
            if (bus.mem_req && !prev) begin
                got[grants] = (bus.mem_addr == 32'h123);
                grants++;
            end
            prev = bus.mem_req;
        end
        bus.if_req = 1'b0;
        bus.dm_rd  = 1'b0;
        vectors++;
        if ({grants, got} !== {32'd8, 8'h88}) begin
            miscompares++;
            $display("FAIL conflict_order: got %0d grants map %b (bit=fetch), expected 8 grants map 10001000", grants, got);
        end
        vectors++;
        if (dmv !== 6) begin
            miscompares++;
            $display("FAIL conflict_dm_valids: got %0d, expected 6", dmv);
        end
        repeat (6) tick();
        vectors++;
        if ({bus.dm_rdata, bus.if_rdata} !== {32'h1122_3344, 32'h1122_3344}) begin
            miscompares++;
            $display("FAIL conflict_rdata: got dm=%h if=%h, expected 11223344 11223344", bus.dm_rdata, bus.if_rdata);
        end
    endtask

    task automatic test_store;
        bit ok;
        resp_wait    = 2;
        bus.dm_wr    = 1'b1;
        bus.dm_addr  = 32'h40;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_len   = LEN_WORD;
        bus.dm_sign  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_req) begin ok = 1'b1; break; end
        end
        vectors++;
        if ({ok, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_len} !== {1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, LEN_WORD}) begin
            miscompares++;
            $display("FAIL store_port: got req=%b we=%b addr=%h wd=%h len=%0d, expected 1 1 00000040 deadbeef 2",
                     ok, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_len);
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.dm_valid) begin ok = 1'b1; break; end
        end
        bus.dm_wr = 1'b0;
        vectors++;
        if ({ok, bus.dm_rdata} !== {1'b1, 32'h1122_3344}) begin
            miscompares++;
            $display("FAIL store_valid_hold: got valid=%b rdata=%h, expected 1 11223344", ok, bus.dm_rdata);
        end
        tick();
    endtask

    task automatic test_fetch_withdrawn;
        bit ok, ifv_seen, d_seen, addr_bad;
        logic prev;
        resp_wait   = 3;
        resp_data   = 32'hCAFE_F00D;
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h200;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_req) begin ok = 1'b1; break; end
        end
        vectors++;
        if ({ok, bus.mem_addr} !== {1'b1, 32'h200}) begin
            miscompares++;
            $display("FAIL wd_grant: got req=%b addr=%h, expected 1 00000200", ok, bus.mem_addr);
        end
        bus.if_req  = 1'b0;
        bus.if_addr = 12'h3FC;
        bus.dm_rd   = 1'b1;
        bus.dm_addr = 32'h80;
        bus.dm_len  = LEN_WORD;
        ifv_seen = 1'b0; d_seen = 1'b0; addr_bad = 1'b0;
        prev = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.if_valid) ifv_seen = 1'b1;
            if (bus.mem_req && !prev && bus.mem_addr == 32'h80 && !bus.mem_we) d_seen = 1'b1;
            if (bus.mem_req && !d_seen && bus.mem_addr !== 32'h200) addr_bad = 1'b1;
            if (bus.dm_valid) break;
            prev = bus.mem_req;
        end
        bus.dm_rd = 1'b0;
        vectors++;
        if ({ifv_seen, addr_bad, d_seen, bus.dm_valid} !== 4'b0011) begin
            miscompares++;
            $display("FAIL wd_sequence: got ifv=%b addr_bad=%b d_grant=%b dmv=%b, expected 0 0 1 1",
                     ifv_seen, addr_bad, d_seen, bus.dm_valid);
        end
        vectors++;
        if ({bus.if_rdata, bus.dm_rdata} !== {32'h1122_3344, 32'hCAFE_F00D}) begin
            miscompares++;
            $display("FAIL wd_rdata: got if=%h dm=%h, expected 11223344 cafef00d", bus.if_rdata, bus.dm_rdata);
        end
        tick();
    endtask

    task automatic test_wait_states;
        bit ok;
        int busy, bad, vcnt;
        resp_wait   = 5;
        resp_data   = 32'h5A5A_A5A5;
        bus.dm_rd   = 1'b1;
        bus.dm_addr = 32'h1F0;
        bus.dm_len  = LEN_HALF;
        bus.dm_sign = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_req) begin ok = 1'b1; break; end
        end
        busy = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.mem_req) break;
            busy++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_len, bus.mem_sign} !== {32'h1F0, 1'b0, LEN_HALF, 1'b1}) bad++;
            bus.dm_addr = $urandom;
            tick();
        end
        vcnt = int'(bus.dm_valid);
        bus.dm_rd   = 1'b0;
        bus.dm_sign = 1'b0;
        repeat (3) begin
            tick();
            vcnt += int'(bus.dm_valid);
        end
        vectors++;
        if ({ok, busy, bad} !== {1'b1, 32'd6, 32'd0}) begin
            miscompares++;
            $display("FAIL ws_stable: got grant=%b busy=%0d unstable=%0d, expected 1 6 0", ok, busy, bad);
        end
        vectors++;
        if ({vcnt, bus.dm_rdata} !== {32'd1, 32'h5A5A_A5A5}) begin
            miscompares++;
            $display("FAIL ws_pulse: got pulses=%0d rdata=%h, expected 1 5a5aa5a5", vcnt, bus.dm_rdata);
        end
    endtask

    task automatic test_random;
        int          m_busy, m_starve, k;
        logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
        logic        m_we, m_sign, e_ifv, e_dmv, dmreq;
        logic [1:0]  m_len;
        m_busy = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_len = '0; m_sign = 1'b0;
        m_ifr = 32'h1122_3344;
        m_dmr = 32'h5A5A_A5A5;
        e_ifv = 1'b0; e_dmv = 1'b0;
        resp_rand = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (bus.if_req) begin
                if (bus.if_valid || $urandom_range(0, 19) == 0) bus.if_req = 1'b0;
                else if ($urandom_range(0, 4) == 0) bus.if_addr = 12'($urandom);
            end else if ($urandom_range(0, 1) == 1) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 12'($urandom);
            end
            if (bus.dm_rd | bus.dm_wr) begin
                if (bus.dm_valid || $urandom_range(0, 19) == 0) begin
                    bus.dm_rd = 1'b0;
                    bus.dm_wr = 1'b0;
                end else if ($urandom_range(0, 4) == 0) bus.dm_addr = $urandom;
            end else if ($urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, 2));
                bus.dm_rd    = (k != 1);
                bus.dm_wr    = (k != 0);
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
                bus.dm_len   = 2'($urandom_range(0, 2));
                bus.dm_sign  = 1'($urandom_range(0, 1));
            end
            #2;
            dmreq = bus.dm_rd | bus.dm_wr;
            vectors++;
            if ({bus.stall_if, bus.stall_mem} !== {(bus.if_req & ~e_ifv) | (dmreq & ~e_dmv), dmreq & ~e_dmv}) begin
                miscompares++;
                $display("FAIL rand_stall cyc %0d: got %b%b, expected %b%b", cyc, bus.stall_if, bus.stall_mem,
                         (bus.if_req & ~e_ifv) | (dmreq & ~e_dmv), dmreq & ~e_dmv);
            end
            // Reference: what the port and requesters should see after this edge
            e_ifv = 1'b0;
            e_dmv = 1'b0;
            if (m_busy != 0) begin
                if (bus.mem_ready) begin
                    if (m_busy == 1 && bus.if_req) begin e_ifv = 1'b1; m_ifr = bus.mem_rdata; end
                    if (m_busy == 2 && dmreq) begin
                        e_dmv = 1'b1;
                        if (!m_we) m_dmr = bus.mem_rdata;
                    end
                    m_busy = 0;
                end
                if (!bus.if_req) m_starve = 0;
            end else if (dmreq && !(bus.if_req && m_starve == MAXS)) begin
                m_busy = 2; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata; m_we = bus.dm_wr;
                m_len = bus.dm_len; m_sign = bus.dm_sign;
                m_starve = bus.if_req ? ((m_starve < MAXS) ? m_starve + 1 : m_starve) : 0;
            end else if (bus.if_req) begin
                m_busy = 1; m_addr = {20'h0, bus.if_addr}; m_we = 1'b0; m_starve = 0;
            end else begin
                m_starve = 0;
            end
            tick();
            vectors++;
            if ({bus.mem_req, bus.if_valid, bus.dm_valid, bus.if_rdata, bus.dm_rdata} !==
                {(m_busy != 0), e_ifv, e_dmv, m_ifr, m_dmr}) begin
                miscompares++;
                $display("FAIL rand_handshake cyc %0d: got req=%b ifv=%b dmv=%b ifd=%h dmd=%h, expected %b %b %b %h %h",
                         cyc, bus.mem_req, bus.if_valid, bus.dm_valid, bus.if_rdata, bus.dm_rdata,
                         (m_busy != 0), e_ifv, e_dmv, m_ifr, m_dmr);
            end
            if (m_busy != 0) begin
                vectors++;
                if ({bus.mem_we, bus.mem_addr} !== {m_we, m_addr} ||
                    (m_busy == 2 && {bus.mem_len, bus.mem_sign} !== {m_len, m_sign}) ||
                    (m_busy == 2 && m_we && bus.mem_wdata !== m_wdata)) begin
                    miscompares++;
                    $display("FAIL rand_port cyc %0d: got we=%b addr=%h len=%0d sign=%b wd=%h, expected %b %h %0d %b %h",
                             cyc, bus.mem_we, bus.mem_addr, bus.mem_len, bus.mem_sign, bus.mem_wdata,
                             m_we, m_addr, m_len, m_sign, m_wdata);
                end
            end
        end
        bus.if_req = 1'b0;
        bus.dm_rd  = 1'b0;
        bus.dm_wr  = 1'b0;
        resp_rand  = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = 12'h0;
        bus.dm_rd    = 1'b0;
        bus.dm_wr    = 1'b0;
        bus.dm_addr  = 32'h0;
        bus.dm_wdata = 32'h0;
        bus.dm_len   = 2'd0;
        bus.dm_sign  = 1'b0;
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_fetch_withdrawn();
        test_wait_states();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
